// File: rtl/switch_input_reader_pkg.sv
// Shared constants and types for the slide-switch reader.
package switch_input_reader_pkg;

  localparam int unsigned CLK_FREQ_HZ             = 100_000_000;
  localparam int unsigned DEBOUNCE_MS             = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned WIDTH_DEFAULT           = 16;

  typedef enum logic {
    EVT_IDLE    = 1'b0,
    EVT_PENDING = 1'b1
  } evt_state_e;

endpackage

// File: rtl/switch_input_reader_debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter, accepted level and edge pulses.
module debounce_channel
  import switch_input_reader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic raw,
  output logic state,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the sys_clk domain.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt   <= '0;
      state <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (s2 == state) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        state <= s2;
        cnt   <= '0;
        rise  <= s2;
        fall  <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/switch_input_reader.sv
// Debounced slide-switch reader with per-bit edge pulses and an accumulating change-event handshake.
module switch_input_reader
  import switch_input_reader_pkg::*;
#(
  parameter int unsigned WIDTH           = WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_state,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_mask,
  output logic [WIDTH-1:0] evt_state
);

  evt_state_e       evt_cur;
  evt_state_e       evt_next;
  logic             valid_next;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] snap_next;
  logic [WIDTH-1:0] chg;

  // Independent debounce channel per switch.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .sys_clk (sys_clk),
      .rst     (rst),
      .raw     (sw_raw[i]),
      .state   (sw_state[i]),
      .rise    (sw_rise[i]),
      .fall    (sw_fall[i])
    );
  end

  assign chg = sw_rise | sw_fall;

  // Event FSM state and registered event outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      evt_cur   <= EVT_IDLE;
      evt_valid <= 1'b0;
      evt_mask  <= '0;
      evt_state <= '0;
    end else begin
      evt_cur   <= evt_next;
      evt_valid <= valid_next;
      evt_mask  <= mask_next;
      evt_state <= snap_next;
    end
  end

  // Next event state: open, accumulate, retire, or retire-and-reopen so no change is lost.
  always_comb begin
    evt_next  = evt_cur;
    mask_next = evt_mask;
    snap_next = evt_state;
    case (evt_cur)
      EVT_IDLE: begin
        if (chg != '0) begin
          evt_next  = EVT_PENDING;
          mask_next = chg;
          snap_next = sw_state;
        end
      end
      EVT_PENDING: begin
        if (evt_ready) begin
          if (chg != '0) begin
            mask_next = chg;
            snap_next = sw_state;
          end else begin
            evt_next  = EVT_IDLE;
            mask_next = '0;
          end
        end else if (chg != '0) begin
          mask_next = evt_mask | chg;
          snap_next = sw_state;
        end
      end
      default: begin
        evt_next  = EVT_IDLE;
        mask_next = '0;
      end
    endcase
    valid_next = (evt_next == EVT_PENDING);
  end

endmodule

// File: tb/tb_switch_input_reader.sv
// Scoreboard bench for switch_input_reader with a short debounce window.
module tb_switch_input_reader;

  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  typedef struct {
    int          cyc;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] state;
  } pulse_t;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] state;
  } evt_t;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic [W-1:0]  sw_raw;
  logic [W-1:0]  sw_state;
  logic [W-1:0]  sw_rise;
  logic [W-1:0]  sw_fall;
  logic          evt_valid;
  logic          evt_ready;
  logic [W-1:0]  evt_mask;
  logic [W-1:0]  evt_state;

  int     cyc = 0;
  int     total = 0;
  int     passed = 0;
  pulse_t pulse_q[$];
  evt_t   evt_q[$];

  switch_input_reader #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_state  (sw_state),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_mask  (evt_mask),
    .evt_state (evt_state)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Drive a new raw vector and predict the pulse D+2 edges later.
  task automatic drive(input logic [15:0] raw, input logic [15:0] r, input logic [15:0] f,
                       input logic [15:0] s);
    pulse_t p;
    sw_raw  = raw;
    p.cyc   = cyc + int'(D) + 2;
    p.rise  = r;
    p.fall  = f;
    p.state = s;
    pulse_q.push_back(p);
  endtask

  // Accept the pending event for one cycle and expect the channel to go idle.
  task automatic handshake(input logic [15:0] m, input logic [15:0] s);
    evt_t e;
    e.mask  = m;
    e.state = s;
    evt_q.push_back(e);
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("hs_valid_clear", 32'(evt_valid), 32'd0);
    check("hs_mask_clear", 32'(evt_mask), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw_state"}, 32'(sw_state), 32'd0);
    check({tag, "_sw_rise"}, 32'(sw_rise), 32'd0);
    check({tag, "_sw_fall"}, 32'(sw_fall), 32'd0);
    check({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check({tag, "_evt_mask"}, 32'(evt_mask), 32'd0);
    check({tag, "_evt_state"}, 32'(evt_state), 32'd0);
  endtask

  // Monitor: compare every presented pulse and every accepted event against the queues.
  always @(negedge sys_clk) begin
    pulse_t p;
    evt_t   e;
    if (!rst) begin
      if ((sw_rise | sw_fall) != '0) begin
        if (pulse_q.size() == 0) begin
          check("unexpected_pulse", {sw_rise, sw_fall}, 32'd0);
        end else begin
          p = pulse_q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(p.cyc));
          check("pulse_rise", 32'(sw_rise), 32'(p.rise));
          check("pulse_fall", 32'(sw_fall), 32'(p.fall));
          check("pulse_state", 32'(sw_state), 32'(p.state));
        end
      end
      if (evt_valid && evt_ready) begin
        if (evt_q.size() == 0) begin
          check("unexpected_event", {evt_mask, evt_state}, 32'd0);
        end else begin
          e = evt_q.pop_front();
          check("evt_mask", 32'(evt_mask), 32'(e.mask));
          check("evt_state", 32'(evt_state), 32'(e.state));
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    sw_raw    = '0;
    evt_ready = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;

    // Bit 0 rises: pulse after D+2 edges, event visible one cycle later.
    drive(16'h0001, 16'h0001, 16'h0000, 16'h0001);
    repeat (6) step();
    check("evt_valid_before", 32'(evt_valid), 32'd0);
    step();
    check("evt_valid_after", 32'(evt_valid), 32'd1);
    check("evt_mask_first", 32'(evt_mask), 32'h0001);
    check("evt_state_first", 32'(evt_state), 32'h0001);

    // Short glitch on bit 3 must be ignored.
    sw_raw = 16'h0009;
    repeat (3) step();
    sw_raw = 16'h0001;
    repeat (8) step();
    check("glitch_state", 32'(sw_state), 32'h0001);
    check("glitch_mask", 32'(evt_mask), 32'h0001);

    // Bit 5 rises while the event is still pending: accumulate.
    drive(16'h0021, 16'h0020, 16'h0000, 16'h0021);
    repeat (10) step();
    check("accum_mask", 32'(evt_mask), 32'h0021);
    check("accum_state", 32'(evt_state), 32'h0021);
    handshake(16'h0021, 16'h0021);

    // Bit 0 falls and bit 7 rises in the same cycle.
    drive(16'h00A0, 16'h0080, 16'h0001, 16'h00A0);
    repeat (8) step();
    // Bit 7 falls exactly when the pending event is accepted.
    drive(16'h0020, 16'h0000, 16'h0080, 16'h0020);
    repeat (6) step();
    begin
      evt_t e;
      e.mask  = 16'h0081;
      e.state = 16'h00A0;
      evt_q.push_back(e);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    check("overlap_valid", 32'(evt_valid), 32'd1);
    check("overlap_mask", 32'(evt_mask), 32'h0080);
    check("overlap_state", 32'(evt_state), 32'h0020);
    handshake(16'h0080, 16'h0020);

    // Return to all-zero.
    drive(16'h0000, 16'h0000, 16'h0020, 16'h0000);
    repeat (8) step();
    handshake(16'h0020, 16'h0000);

    // Reset with a count of 3 in progress on bit 2; count restarts afterwards.
    sw_raw = 16'h0004;
    repeat (5) step();
    rst = 1'b1;
    step();
    check_all_zero("midreset");
    rst = 1'b0;
    drive(16'h0004, 16'h0004, 16'h0000, 16'h0004);
    repeat (5) step();
    check("restart_not_yet", 32'(sw_state), 32'd0);
    step();
    check("restart_done", 32'(sw_state), 32'h0004);
    step();
    handshake(16'h0004, 16'h0004);

    // All sixteen switches change together.
    drive(16'h0000, 16'h0000, 16'h0004, 16'h0000);
    repeat (8) step();
    handshake(16'h0004, 16'h0000);
    drive(16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF);
    repeat (8) step();
    check("all_state", 32'(sw_state), 32'hFFFF);
    handshake(16'hFFFF, 16'hFFFF);

    repeat (4) step();
    check("pulse_queue_drained", 32'(pulse_q.size()), 32'd0);
    check("evt_queue_drained", 32'(evt_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
